main_fsm_decoder: RTL
=====================

Name: main_fsm_decoder

Overview:
- Moore control FSM for the multicycle ARM datapath; directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute and writeback cycles from Op and Funct.
- Drives ALUOp to the ALU decoder and the datapath mux selects.
- Drives raw write enables (RegW, MemW, NextPC, Branch); the conditional logic gates these downstream.

Parameters:
STATE_W, 4, width of the state register and of the State debug output; must be >= 4.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset; state forced to FETCH immediately
Op  input  2  instruction class, Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
Funct  input  6  Instr[25:20]; Funct[5] = I (immediate), Funct[0] = S/L (load for memory ops)
IRWrite  output  1  instruction register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result
ALUSrcA  output  2  ALU A select: 00 = Rn, 01 = PC
ALUSrcB  output  2  ALU B select: 00 = Rm, 01 = extended immediate, 10 = constant 4
ResultSrc  output  2  result select: 00 = ALU out register, 01 = memory data, 10 = ALU result
ALUOp  output  1  to ALU decoder: 1 = decode Funct, 0 = force ADD
NextPC  output  1  PC update enable, raw
RegW  output  1  register-file write, raw
MemW  output  1  memory write, raw
Branch  output  1  branch request, raw
State  output  STATE_W  current state encoding, for debug and bench

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, HALT=10 (HALT exists only with the macro).
- State register is the only storage. Outputs are a pure function of State (Moore), so outputs settle in the same cycle the state is entered.
- Transitions, one per clock:
  - FETCH -> DECODE.
  - DECODE: Op=00 and Funct[5]=1 -> EXECUTEI; Op=00 and Funct[5]=0 -> EXECUTER; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> see Optional Feature.
  - MEMADR: Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB. EXECUTER and EXECUTEI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
  - Unused encodings -> FETCH.
- Op and Funct are sampled only in DECODE and MEMADR; they are ignored in every other state.
- Outputs per state. Any signal not listed is 0, including selects; there are no X outputs.
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - HALT: all outputs 0.
- Cycle counts: LDR 5, STR 4, data-processing 4, branch 3.
- Reset:
  - While reset is high: State=FETCH and IRWrite=NextPC=RegW=MemW=Branch=0. Selects take their FETCH values.
  - After reset deasserts, the first rising edge executes FETCH normally.
  - Reset asserted mid-instruction aborts it at once; no pending RegW or MemW is issued afterwards.

Optional Feature:
- Macro: MAIN_FSM_UNDEF_TRAP_EN.
- Defined: DECODE with Op=11 -> HALT. HALT is absorbing until reset, and all outputs are 0 there.
- Undefined: DECODE with Op=11 -> FETCH. The instruction acts as a 2-cycle NOP; the PC has already advanced in FETCH.

Test Plan:
- Reset held 3 cycles, then released -> State=0 and all enables 0 during reset; the first edge after release gives State=1.
- Op=00, Funct=6'b001000 (ADD register) -> State sequence 0,1,6,8,0; ALUOp=1 only in state 6; RegW=1 only in state 8.
- Op=00, Funct=6'b100101 (SUBS immediate) -> sequence 0,1,7,8,0; ALUSrcB=01 and ALUOp=1 in state 7.
- Op=01, Funct=6'b011001 (LDR) -> sequence 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4.
- Op=01, Funct=6'b011000 (STR), then Op=10 (B) -> STR sequence 0,1,2,5,0 with MemW=1 in state 5 only; B sequence 0,1,9,0 with Branch=1 in state 9.
- Op=11 -> without the macro: sequence 0,1,0. With the macro: 0,1,10, held for 10+ cycles until reset. Also assert reset during state 4 (MEMWB) -> RegW drops to 0 immediately and State=0.

Source files
------------

// File: rtl/main_fsm_decoder.sv
// main_fsm_decoder: Moore control FSM for the multicycle ARM datapath.
// Steps each instruction through fetch, decode, execute and writeback, and
// drives the datapath mux selects, ALUOp and the raw write enables.
// Optional build macro: MAIN_FSM_UNDEF_TRAP_EN. When it is defined, an
// undefined instruction (Op=11) traps into an absorbing HALT state. When it
// is not defined, Op=11 is treated as a 2-cycle NOP.

module main_fsm_decoder #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] State
);

    // The encodings are implicit and sequential, so FETCH=0 through BRANCH=9.
    // HALT=10 exists only in the trap build.
    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
`ifdef MAIN_FSM_UNDEF_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    // Raw per-state outputs, before the reset gating is applied.
    logic       irwrite_raw;
    logic       adrsrc_raw;
    logic [1:0] alusrca_raw;
    logic [1:0] alusrcb_raw;
    logic [1:0] resultsrc_raw;
    logic       aluop_raw;
    logic       nextpc_raw;
    logic       regw_raw;
    logic       memw_raw;
    logic       branch_raw;

    // Only I (bit 5) and S/L (bit 0) steer the sequence. The ALU decoder
    // consumes the remaining Funct bits.
    logic unused_funct_bits;
    assign unused_funct_bits = ^Funct[4:1];

    // State register. Reset is asynchronous and aborts any instruction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Op and Funct are looked at only in DECODE and MEMADR.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
`ifdef MAIN_FSM_UNDEF_TRAP_EN
                        state_d = HALT;
`else
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
`ifdef MAIN_FSM_UNDEF_TRAP_EN
            HALT:     state_d = HALT;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode. Every output is 0 unless the current state sets it.
    always_comb begin
        irwrite_raw   = 1'b0;
        adrsrc_raw    = 1'b0;
        alusrca_raw   = 2'b00;
        alusrcb_raw   = 2'b00;
        resultsrc_raw = 2'b00;
        aluop_raw     = 1'b0;
        nextpc_raw    = 1'b0;
        regw_raw      = 1'b0;
        memw_raw      = 1'b0;
        branch_raw    = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite_raw   = 1'b1;
                nextpc_raw    = 1'b1;
                alusrca_raw   = 2'b01;
                alusrcb_raw   = 2'b10;
                resultsrc_raw = 2'b10;
            end
            DECODE: begin
                alusrca_raw   = 2'b01;
                alusrcb_raw   = 2'b10;
                resultsrc_raw = 2'b10;
            end
            MEMADR: begin
                alusrcb_raw   = 2'b01;
            end
            MEMREAD: begin
                adrsrc_raw    = 1'b1;
            end
            MEMWB: begin
                resultsrc_raw = 2'b01;
                regw_raw      = 1'b1;
            end
            MEMWRITE: begin
                adrsrc_raw    = 1'b1;
                memw_raw      = 1'b1;
            end
            EXECUTER: begin
                aluop_raw     = 1'b1;
            end
            EXECUTEI: begin
                alusrcb_raw   = 2'b01;
                aluop_raw     = 1'b1;
            end
            ALUWB: begin
                regw_raw      = 1'b1;
            end
            BRANCH: begin
                alusrcb_raw   = 2'b01;
                resultsrc_raw = 2'b10;
                branch_raw    = 1'b1;
            end
            default: begin
                // HALT and unused encodings keep every output at 0.
            end
        endcase
    end

    // While reset is held, the state sits in FETCH. FETCH would normally
    // assert IRWrite and NextPC, so all enables are masked here. The selects
    // keep their FETCH values.
    assign IRWrite   = irwrite_raw & ~reset;
    assign NextPC    = nextpc_raw  & ~reset;
    assign RegW      = regw_raw    & ~reset;
    assign MemW      = memw_raw    & ~reset;
    assign Branch    = branch_raw  & ~reset;
    assign AdrSrc    = adrsrc_raw;
    assign ALUSrcA   = alusrca_raw;
    assign ALUSrcB   = alusrcb_raw;
    assign ResultSrc = resultsrc_raw;
    assign ALUOp     = aluop_raw;
    assign State     = state_q;

endmodule
